wr_flag_gen: RTL and testbench

Parametrised write-domain pointer and flag generator for the asynchronous FIFO. It owns the write pointer and gates push requests. It compares its write pointer against the read pointer already synchronised into clk_w, then produces a registered fill level, full, hysteretic almost-full, a wrap pulse and a configurable-depth delayed almost-full. It sits between the write client and the dual-port RAM / write-to-read pointer synchroniser.

---
 rtl/fifo_flag_pkg.sv | 31 +++
 rtl/wr_flag_gen_if.sv | 41 ++++
 rtl/ptr_gray2bin.sv | 11 +
 rtl/wr_flag_gen.sv | 137 +++++++++++++
 tb/tb_wr_flag_gen.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/fifo_flag_pkg.sv
// Shared types and pointer helpers for the async-FIFO flag blocks.
// Gray/binary helpers work on 32-bit containers; callers cast to their pointer width.
package fifo_flag_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        ALMOST = 2'd1,
        FULL   = 2'd2
    } af_state_t;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix-XOR from the MSB down; zero upper bits leave narrower widths unaffected.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        b = b ^ (b >> 16);
        return b;
    endfunction

endpackage

// File: rtl/wr_flag_gen_if.sv
// Write-client / flag bus of the write-domain flag generator.
// WR_FLAG_WRAP_CNT_EN adds the saturating wrap counter signal.
interface wr_flag_gen_if #(
    parameter int ADDR_W = 4
);
    logic              wr_req;
    logic [ADDR_W:0]   rd_ptr_gray_s;
    logic              wr_ack;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   wr_ptr_gray;
    logic [ADDR_W:0]   level;
    logic              full;
    logic              alm_full;
    logic              alm_full_dly;
    logic              wrap_pulse;
`ifdef WR_FLAG_WRAP_CNT_EN
    logic [15:0]       wrap_cnt;

    modport master (
        output wr_req, rd_ptr_gray_s,
        input  wr_ack, wr_addr, wr_ptr_gray, level, full, alm_full,
               alm_full_dly, wrap_pulse, wrap_cnt
    );
    modport slave (
        input  wr_req, rd_ptr_gray_s,
        output wr_ack, wr_addr, wr_ptr_gray, level, full, alm_full,
               alm_full_dly, wrap_pulse, wrap_cnt
    );
`else
    modport master (
        output wr_req, rd_ptr_gray_s,
        input  wr_ack, wr_addr, wr_ptr_gray, level, full, alm_full,
               alm_full_dly, wrap_pulse
    );
    modport slave (
        input  wr_req, rd_ptr_gray_s,
        output wr_ack, wr_addr, wr_ptr_gray, level, full, alm_full,
               alm_full_dly, wrap_pulse
    );
`endif
endinterface

// File: rtl/ptr_gray2bin.sv
// Combinational Gray-to-binary converter, shared by the write and read flag blocks.
module ptr_gray2bin #(
    parameter int W = 5
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[W-1:i];
    end
endmodule

// File: rtl/wr_flag_gen.sv
// Write-domain pointer and flag generator for the async FIFO.
// Optional macro WR_FLAG_WRAP_CNT_EN adds a saturating 16-bit wrap counter.
module wr_flag_gen
    import fifo_flag_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int AF_SET     = 12,
    parameter int AF_HYST    = 2,
    parameter int DLY_STAGES = 1
) (
    input logic          clk_w,
    input logic          rst_w,
    wr_flag_gen_if.slave bus
);
    localparam int              DEPTH     = depth_of(ADDR_W);
    localparam int              PW        = ADDR_W + 1;
    localparam logic [PW-1:0]   DEPTH_L   = PW'(DEPTH);
    localparam logic [PW-1:0]   AF_SET_L  = PW'(AF_SET);
    localparam logic [PW-1:0]   AF_CLR_L  = PW'(AF_SET - AF_HYST);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [PW-1:0]         r_wr_bin;
    logic [PW-1:0]         r_wr_ptr_gray;
    logic [PW-1:0]         r_level;
    logic                  r_full;
    logic                  r_wrap_pulse;
    logic [DLY_STAGES-1:0] r_af_dly;
    af_state_t             r_state;

    logic [PW-1:0]         w_rd_bin;
    logic [PW-1:0]         w_wr_bin_next;
    logic [PW-1:0]         w_level_next;
    logic                  w_wr_ack;
    logic                  w_alm_full;
    af_state_t             w_state_next;

    ptr_gray2bin #(.W(PW)) u_rd_g2b (
        .i_gray (bus.rd_ptr_gray_s),
        .o_bin  (w_rd_bin)
    );

    assign w_wr_ack      = bus.wr_req & ~r_full & ~rst_w;
    assign w_wr_bin_next = r_wr_bin + {{ADDR_W{1'b0}}, w_wr_ack};
    // Using the post-push pointer lets full register together with the last pointer.
    assign w_level_next  = w_wr_bin_next - w_rd_bin;

    always_ff @(posedge clk_w or posedge rst_w) begin
        if (rst_w) begin
            r_wr_bin      <= '0;
            r_wr_ptr_gray <= '0;
            r_level       <= '0;
            r_full        <= 1'b0;
            r_wrap_pulse  <= 1'b0;
        end else begin
            r_wr_bin      <= w_wr_bin_next;
            r_wr_ptr_gray <= PW'(bin2gray(32'(w_wr_bin_next)));
            r_level       <= w_level_next;
            r_full        <= (w_level_next == DEPTH_L);
            r_wrap_pulse  <= w_wr_ack & (r_wr_bin[ADDR_W-1:0] == LAST_ADDR);
        end
    end

    always_ff @(posedge clk_w or posedge rst_w) begin
        if (rst_w) begin
            r_state <= NORMAL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            NORMAL: begin
                if (w_level_next == DEPTH_L) begin
                    w_state_next = FULL;
                end else if (w_level_next >= AF_SET_L) begin
                    w_state_next = ALMOST;
                end
            end
            ALMOST: begin
                if (w_level_next == DEPTH_L) begin
                    w_state_next = FULL;
                end else if (w_level_next < AF_CLR_L) begin
                    w_state_next = NORMAL;
                end
            end
            FULL: begin
                if (w_level_next < AF_CLR_L) begin
                    w_state_next = NORMAL;
                end else if (w_level_next < DEPTH_L) begin
                    w_state_next = ALMOST;
                end
            end
            default: w_state_next = NORMAL;
        endcase
    end

    always_comb begin
        w_alm_full = (r_state != NORMAL);
    end

    always_ff @(posedge clk_w or posedge rst_w) begin
        if (rst_w) begin
            r_af_dly <= '0;
        end else begin
            r_af_dly[0] <= w_alm_full;
            for (int i = 1; i < DLY_STAGES; i++) begin
                r_af_dly[i] <= r_af_dly[i-1];
            end
        end
    end

`ifdef WR_FLAG_WRAP_CNT_EN
    logic [15:0] r_wrap_cnt;

    always_ff @(posedge clk_w or posedge rst_w) begin
        if (rst_w) begin
            r_wrap_cnt <= '0;
        end else if (r_wrap_pulse && (r_wrap_cnt != 16'hFFFF)) begin
            r_wrap_cnt <= r_wrap_cnt + 16'd1;
        end
    end

    assign bus.wrap_cnt = r_wrap_cnt;
`endif

    assign bus.wr_ack       = w_wr_ack;
    assign bus.wr_addr      = r_wr_bin[ADDR_W-1:0];
    assign bus.wr_ptr_gray  = r_wr_ptr_gray;
    assign bus.level        = r_level;
    assign bus.full         = r_full;
    assign bus.alm_full     = w_alm_full;
    assign bus.alm_full_dly = r_af_dly[DLY_STAGES-1];
    assign bus.wrap_pulse   = r_wrap_pulse;

endmodule

// File: tb/tb_wr_flag_gen.sv
// Randomised and directed bench for wr_flag_gen against a push/pop counting model.
module tb_wr_flag_gen;
    localparam int ADDR_W  = 3;
    localparam int DEPTH   = 8;
    localparam int AF_SET  = 6;
    localparam int AF_HYST = 2;
    localparam int DLY     = 2;

    logic clk_w = 1'b0;
    logic rst_w = 1'b1;

    wr_flag_gen_if #(.ADDR_W(ADDR_W)) bus();

    wr_flag_gen #(
        .ADDR_W     (ADDR_W),
        .AF_SET     (AF_SET),
        .AF_HYST    (AF_HYST),
        .DLY_STAGES (DLY)
    ) dut (
        .clk_w (clk_w),
        .rst_w (rst_w),
        .bus   (bus)
    );

    always #5 clk_w = ~clk_w;

    int compared   = 0;
    int mismatched = 0;

    // Model: total pushes and total reads since reset; level is their difference.
    int wrCount, rdCount, mLevel, mWrapCnt;
    bit mFull, mAlm, mWrap;
    bit almHist[$];
    int obsAcks, obsWraps;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] grayOf(input int n);
        logic [3:0] b;
        b = 4'(n % 16);
        return b ^ (b >> 1);
    endfunction

    task automatic resetModel();
        wrCount  = 0;
        rdCount  = 0;
        mLevel   = 0;
        mWrapCnt = 0;
        mFull    = 1'b0;
        mAlm     = 1'b0;
        mWrap    = 1'b0;
        almHist.delete();
        for (int i = 0; i < DLY; i++) almHist.push_back(1'b0);
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, ".level"},    bus.level, mLevel);
        checkOutput({tag, ".full"},     bus.full, mFull);
        checkOutput({tag, ".alm"},      bus.alm_full, mAlm);
        checkOutput({tag, ".alm_dly"},  bus.alm_full_dly, almHist[0]);
        checkOutput({tag, ".wrap"},     bus.wrap_pulse, mWrap);
        checkOutput({tag, ".wr_addr"},  bus.wr_addr, wrCount % DEPTH);
        checkOutput({tag, ".gray"},     bus.wr_ptr_gray, grayOf(wrCount));
`ifdef WR_FLAG_WRAP_CNT_EN
        checkOutput({tag, ".wrap_cnt"}, bus.wrap_cnt, mWrapCnt);
`endif
    endtask

    // One clk_w cycle: drive on negedge, check wr_ack, then check registers after the edge.
    task automatic applyStimulus(input bit req, input int rdAdv);
        bit expAck, wrapExp, newAlm;
        @(negedge clk_w);
        rdCount += rdAdv;
        bus.wr_req        = req;
        bus.rd_ptr_gray_s = grayOf(rdCount);
        expAck = req && !mFull;
        #1;
        checkOutput("wr_ack", bus.wr_ack, expAck);
        if (bus.wr_ack === 1'b1) obsAcks++;
        wrapExp = expAck && ((wrCount % DEPTH) == DEPTH - 1);
        @(posedge clk_w);
        if (mWrap && mWrapCnt < 16'hFFFF) mWrapCnt++;
        wrCount += int'(expAck);
        mLevel = wrCount - rdCount;
        mFull  = (mLevel == DEPTH);
        newAlm = mAlm;
        if (mLevel >= AF_SET) newAlm = 1'b1;
        else if (mLevel < AF_SET - AF_HYST) newAlm = 1'b0;
        mAlm = newAlm;
        almHist.push_back(mAlm);
        mWrap = wrapExp;
        #1;
        checkRegs("cyc");
        void'(almHist.pop_front());
        if (bus.wrap_pulse === 1'b1) obsWraps++;
    endtask

    // Asynchronous reset: outputs must clear before the next clock edge.
    task automatic doReset();
        @(negedge clk_w);
        bus.wr_req = 1'b1;
        #2;
        rst_w = 1'b1;
        bus.rd_ptr_gray_s = '0;
        #1;
        checkOutput("rst.ack",     bus.wr_ack, 0);
        checkOutput("rst.level",   bus.level, 0);
        checkOutput("rst.full",    bus.full, 0);
        checkOutput("rst.alm",     bus.alm_full, 0);
        checkOutput("rst.alm_dly", bus.alm_full_dly, 0);
        checkOutput("rst.wrap",    bus.wrap_pulse, 0);
        checkOutput("rst.addr",    bus.wr_addr, 0);
        checkOutput("rst.gray",    bus.wr_ptr_gray, 0);
`ifdef WR_FLAG_WRAP_CNT_EN
        checkOutput("rst.wrap_cnt", bus.wrap_cnt, 0);
`endif
        @(posedge clk_w);
        @(negedge clk_w);
        bus.wr_req = 1'b0;
        rst_w = 1'b0;
        resetModel();
    endtask

    initial begin
        bus.wr_req        = 1'b0;
        bus.rd_ptr_gray_s = '0;
        resetModel();
        doReset();

        $display("[TB] scenario 1: fill with dropped pushes");
        obsAcks = 0;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 0);
        checkOutput("t1.acks", obsAcks, 8);
        checkOutput("t1.level", bus.level, 8);
        checkOutput("t1.full", bus.full, 1);
        checkOutput("t1.gray", bus.wr_ptr_gray, 4'b1100);

        $display("[TB] scenario 3: large read jump from full");
        applyStimulus(1'b0, 7);
        checkOutput("t3.level", bus.level, 1);
        checkOutput("t3.full", bus.full, 0);
        checkOutput("t3.alm", bus.alm_full, 0);

        $display("[TB] scenario 6: push and read at full");
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 0);
        checkOutput("t6.full_before", bus.full, 1);
        obsAcks = 0;
        applyStimulus(1'b1, 1);
        checkOutput("t6.ack_blocked", obsAcks, 0);
        checkOutput("t6.level7", bus.level, 7);
        applyStimulus(1'b1, 0);
        checkOutput("t6.ack_next", obsAcks, 1);

        $display("[TB] scenario 2: almost-full hysteresis");
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 0);
        checkOutput("t2.alm_set", bus.alm_full, 1);
        applyStimulus(1'b0, 0);
        applyStimulus(1'b0, 0);
        checkOutput("t2.alm_dly", bus.alm_full_dly, 1);
        applyStimulus(1'b0, 1);
        checkOutput("t2.alm_l5", bus.alm_full, 1);
        applyStimulus(1'b0, 1);
        checkOutput("t2.alm_l4", bus.alm_full, 1);
        applyStimulus(1'b0, 1);
        checkOutput("t2.alm_l3", bus.alm_full, 0);

        $display("[TB] scenario 4: steady push/read over three wraps");
        doReset();
        obsWraps = 0;
        applyStimulus(1'b1, 0);
        applyStimulus(1'b1, 0);
        for (int i = 0; i < 22; i++) applyStimulus(1'b1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0);
        checkOutput("t4.wraps", obsWraps, 3);
`ifdef WR_FLAG_WRAP_CNT_EN
        checkOutput("t4.wrap_cnt", bus.wrap_cnt, 3);
`endif

        $display("[TB] scenario 5: reset mid-fill");
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 0);
        checkOutput("t5.alm_pre", bus.alm_full, 0);
        doReset();
        applyStimulus(1'b1, 0);
        checkOutput("t5.level1", bus.level, 1);

        $display("[TB] random traffic");
        doReset();
        for (int i = 0; i < 400; i++) begin
            int room;
            int adv;
            room = wrCount - rdCount;
            adv  = 0;
            if (room > 0) begin
                case ($urandom_range(0, 3))
                    0: adv = 0;
                    1: adv = 1;
                    2: adv = (room > 1) ? 2 : 1;
                    default: adv = $urandom_range(0, room);
                endcase
            end
            applyStimulus(($urandom % 4) != 0, adv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
